// File: rtl/lsu_mem_if.sv
// Load/store unit between the single-cycle core datapath and a req/ack data-memory bus.
// Each legal access takes IDLE -> BUSY -> DONE and stalls the core until the DONE cycle.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [31:0] addr_q,   addr_d;
  logic        we_q,     we_d;
  logic [3:0]  be_q,     be_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [2:0]  f3_q,     f3_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        buserr_q, buserr_d;

  logic access, is_write, f3_legal, aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign access   = MemRead | MemWrite;
  assign is_write = MemWrite;

  // Unsigned-load encodings are meaningless for stores, so they are rejected there.
  always_comb begin
    case (Funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~is_write;
      default:                f3_legal = 1'b0;
    endcase
    case (Funct3[1:0])
      2'b01:   aligned = ~ALUResult[0];
      2'b10:   aligned = (ALUResult[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteData;
    if (is_write) begin
      case (Funct3[1:0])
        2'b00: begin
          st_wdata = {4{WriteData[7:0]}};
          case (ALUResult[1:0])
            2'd0:    st_be = 4'b0001;
            2'd1:    st_be = 4'b0010;
            2'd2:    st_be = 4'b0100;
            default: st_be = 4'b1000;
          endcase
        end
        2'b01: begin
          st_wdata = {2{WriteData[15:0]}};
          st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = WriteData;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    rdata_d   = rdata_q;
    buserr_d  = buserr_q;
    Stall     = 1'b0;
    AccessErr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (f3_legal && aligned) begin
            Stall   = 1'b1;
            state_d = S_BUSY;
            cnt_d   = 16'd0;
            addr_d  = ALUResult;
            we_d    = is_write;
            be_d    = st_be;
            wdata_d = st_wdata;
            f3_d    = Funct3;
          end else begin
            AccessErr = 1'b1;
          end
        end
      end
      S_BUSY: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        // An ack on the final allowed cycle still completes the access normally.
        if (mem_ack) begin
          if (!we_q) rdata_d = load_extend(f3_q, addr_q[1:0], mem_rdata);
          state_d = S_DONE;
        end else if (cnt_q + 16'd1 == TMO) begin
          rdata_d  = 32'd0;
          buserr_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        cnt_d    = 16'd0;
        buserr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      rdata_q  <= 32'd0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign mem_req   = (state_q == S_BUSY);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ReadData  = rdata_q;
  assign BusErr    = buserr_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed scenarios plus randomized accesses checked against
// an arithmetic model of access legality, lane placement and load extension.
module tb_lsu_mem_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, AccessErr, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'd0;

  lsu_mem_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 1 << s;
  endfunction

  function automatic bit ref_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!wr && (f3 == 3'd4 || f3 == 3'd5)));
    if (!ok) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned sz, bits;
    logic [63:0] v;
    sz = size_of(f3);
    if (sz == 4) return w;
    bits = 8 * sz;
    v = {32'd0, w} >> (8 * (a % 4));
    v = v % (64'd1 << bits);
    if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    if (!wr) return 4'hF;
    m = ((1 << size_of(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input bit wr, input logic [2:0] f3,
                                            input logic [31:0] d);
    if (wr && size_of(f3) == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (wr && size_of(f3) == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  // ack_at = k acknowledges on the k-th BUSY cycle; 0 never acknowledges.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdw);
    bit legal, acked, timed_out;
    int n;
    legal = ref_legal(wr, f3, a);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    chk({tag, ".idle_stall"}, 32'(Stall), 32'(legal));
    chk({tag, ".idle_aerr"}, 32'(AccessErr), 32'(!legal));
    chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
    if (!legal) begin
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk({tag, ".err_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".err_stall"}, 32'(Stall), 32'd0);
      chk({tag, ".err_rd"}, ReadData, exp_rd);
      return;
    end
    n = 0;
    acked = 1'b0;
    timed_out = 1'b0;
    while (!acked && !timed_out) begin
      @(negedge clk);
      n++;
      acked = (n == ack_at);
      mem_ack = acked;
      mem_rdata = acked ? rdw : $urandom;
      #1;
      chk({tag, ".busy_req"}, 32'(mem_req), 32'd1);
      chk({tag, ".busy_stall"}, 32'(Stall), 32'd1);
      chk({tag, ".busy_addr"}, mem_addr, a & 32'hFFFF_FFFC);
      chk({tag, ".busy_we"}, 32'(mem_we), 32'(wr));
      chk({tag, ".busy_be"}, 32'(mem_be), 32'(ref_be(wr, f3, a)));
      chk({tag, ".busy_wdata"}, mem_wdata, ref_wdata(wr, f3, wd));
      if (!acked && n >= TMO) timed_out = 1'b1;
    end
    if (timed_out) exp_rd = 32'd0;
    else if (!wr) exp_rd = ref_load(f3, a, rdw);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    chk({tag, ".done_stall"}, 32'(Stall), 32'd0);
    chk({tag, ".done_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".done_buserr"}, 32'(BusErr), 32'(timed_out));
    chk({tag, ".done_rd"}, ReadData, exp_rd);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk({tag, ".post_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".post_buserr"}, 32'(BusErr), 32'd0);
    chk({tag, ".post_stall"}, 32'(Stall), 32'd0);
    chk({tag, ".post_rd"}, ReadData, exp_rd);
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    ALUResult = 32'd0; WriteData = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.rd", ReadData, 32'd0);
    chk("rst.buserr", 32'(BusErr), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    reset = 1'b0;

    access("lw100", 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    access("lb203", 1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80112233);
    access("lbu203", 1, 0, 3'b100, 32'h203, 32'h0, 3, 32'h80112233);
    access("lhu202", 1, 0, 3'b101, 32'h202, 32'h0, 1, 32'h80112233);
    access("lh200", 1, 0, 3'b001, 32'h200, 32'h0, 2, 32'h80112233);
    access("sb301", 0, 1, 3'b000, 32'h301, 32'h000000A5, 1, 32'h0);
    access("sh302", 0, 1, 3'b001, 32'h302, 32'h00001234, 2, 32'h0);
    access("sw_rw", 1, 1, 3'b010, 32'h304, 32'hCAFEF00D, 1, 32'h11111111);
    access("lw102", 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
    access("lh101", 1, 0, 3'b001, 32'h101, 32'h0, 1, 32'h0);
    access("f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
    access("sbu", 0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
    access("lw_ack_last", 1, 0, 3'b010, 32'h500, 32'h0, TMO, 32'h76543210);
    access("lw_tmo", 1, 0, 3'b010, 32'h600, 32'h0, 0, 32'h0);

    // Late ack while idle must not disturb anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack.rd", ReadData, exp_rd);
    chk("late_ack.req", 32'(mem_req), 32'd0);
    chk("late_ack.stall", 32'(Stall), 32'd0);

    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      int sel;
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      access("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, TMO), $urandom);
    end

    access("lw_pre_rst", 1, 0, 3'b010, 32'h700, 32'h0, 1, 32'hA5A55A5A);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h400;
    #1;
    chk("rstb.idle_stall", 32'(Stall), 32'd1);
    @(negedge clk);
    #1;
    chk("rstb.busy1_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #1;
    chk("rstb.busy2_req", 32'(mem_req), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    #1;
    exp_rd = 32'd0;
    chk("rstb.req", 32'(mem_req), 32'd0);
    chk("rstb.stall", 32'(Stall), 32'd0);
    chk("rstb.rd", ReadData, exp_rd);
    chk("rstb.addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rstb.late_rd", ReadData, exp_rd);
    chk("rstb.late_req", 32'(mem_req), 32'd0);
    chk("rstb.late_buserr", 32'(BusErr), 32'd0);

    access("lw_after_rst", 1, 0, 3'b010, 32'h800, 32'h0, 1, 32'h0BADCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
